// File: rtl/hazard_ctrl.sv
// Stall and forwarding-select generator for the 5-stage MIPS pipeline.
// In: D-stage rs/rt/rd, krt, Tuse, dreg, Tnew. Out: stall, fwd_d/e/m selects.
module hazard_ctrl #(
  parameter int AW = 5,
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [AW-1:0] d_rd,
  input  logic          d_krt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [1:0]    d_dreg,
  input  logic [TW-1:0] d_tnew,
  output logic          stall,
  output logic [1:0]    fwd_d_rs,
  output logic [1:0]    fwd_d_rt,
  output logic [1:0]    fwd_e_rs,
  output logic [1:0]    fwd_e_rt,
  output logic [1:0]    fwd_m_rt
);

  localparam logic [TW-1:0] TNONE = '1;
  localparam logic [AW-1:0] RA    = AW'(31);

  logic [AW-1:0] e_rs, e_rt, e_dst;
  logic [TW-1:0] e_tnew;
  logic [AW-1:0] m_rt, m_dst;
  logic [TW-1:0] m_tnew;
  logic [AW-1:0] w_dst;

  logic [AW-1:0] d_dst;
  logic          rs_rd;
  logic          stall_rs;
  logic          stall_rt;

  function automatic logic [TW-1:0] sat_dec(
    input logic [TW-1:0] t
  );
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  function automatic logic hit(
    input logic [AW-1:0] a,
    input logic [AW-1:0] dst
  );
    return (a == dst) && (a != '0);
  endfunction

  // E holds the younger result, so it is checked first.
  function automatic logic [1:0] sel_d(
    input logic [AW-1:0] a,
    input logic [AW-1:0] ed,
    input logic [TW-1:0] et,
    input logic [AW-1:0] md,
    input logic [TW-1:0] mt
  );
    if (hit(a, ed) && et == '0)
      return 2'd1;
    else if (hit(a, md) && mt == '0)
      return 2'd2;
    else
      return 2'd0;
  endfunction

  // An M match still waiting on its result drops
  // through to W; a stall upstream rules that out.
  function automatic logic [1:0] sel_e(
    input logic [AW-1:0] a,
    input logic [AW-1:0] md,
    input logic [TW-1:0] mt,
    input logic [AW-1:0] wd
  );
    if (hit(a, md) && mt == '0)
      return 2'd2;
    else if (hit(a, wd))
      return 2'd3;
    else
      return 2'd0;
  endfunction

  function automatic logic needs_wait(
    input logic [AW-1:0] a,
    input logic [TW-1:0] tuse,
    input logic [AW-1:0] ed,
    input logic [TW-1:0] et,
    input logic [AW-1:0] md,
    input logic [TW-1:0] mt
  );
    return (hit(a, ed) && tuse < et) ||
           (hit(a, md) && tuse < mt);
  endfunction

  always_comb begin
    d_dst = '0;
    unique case (d_dreg)
      2'd0:    d_dst = d_rt;
      2'd1:    d_dst = d_rd;
      2'd2:    d_dst = RA;
      default: d_dst = '0;
    endcase
  end

  assign rs_rd = (d_tuse_rs != TNONE);

  assign stall_rs = rs_rd &&
    needs_wait(d_rs, d_tuse_rs,
               e_dst, e_tnew, m_dst, m_tnew);

  assign stall_rt = d_krt &&
    needs_wait(d_rt, d_tuse_rt,
               e_dst, e_tnew, m_dst, m_tnew);

  assign stall = stall_rs | stall_rt;

  assign fwd_d_rs =
    sel_d(d_rs, e_dst, e_tnew, m_dst, m_tnew);
  assign fwd_d_rt =
    sel_d(d_rt, e_dst, e_tnew, m_dst, m_tnew);

  assign fwd_e_rs = sel_e(e_rs, m_dst, m_tnew, w_dst);
  assign fwd_e_rt = sel_e(e_rt, m_dst, m_tnew, w_dst);

  assign fwd_m_rt = hit(m_rt, w_dst) ? 2'd3 : 2'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_rs   <= '0;
      e_rt   <= '0;
      e_dst  <= '0;
      e_tnew <= '0;
    end else if (stall) begin
      e_rs   <= '0;
      e_rt   <= '0;
      e_dst  <= '0;
      e_tnew <= '0;
    end else begin
      e_rs   <= rs_rd ? d_rs : '0;
      e_rt   <= d_krt ? d_rt : '0;
      e_dst  <= d_dst;
      e_tnew <= sat_dec(d_tnew);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rt   <= '0;
      m_dst  <= '0;
      m_tnew <= '0;
      w_dst  <= '0;
    end else begin
      m_rt   <= e_rt;
      m_dst  <= e_dst;
      m_tnew <= sat_dec(e_tnew);
      w_dst  <= m_dst;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed cycle table, reset corner, random vs model.
// Model tracks in-flight instructions and derives Tnew from stage age.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] d_rs, d_rt, d_rd;
  logic       d_krt;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_dreg, d_tnew;
  logic       stall;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.AW(5), .TW(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd),
    .d_krt(d_krt), .d_tuse_rs(d_tuse_rs),
    .d_tuse_rt(d_tuse_rt), .d_dreg(d_dreg),
    .d_tnew(d_tnew), .stall(stall),
    .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
    .fwd_m_rt(fwd_m_rt)
  );

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic       krt;
    logic [1:0] turs, turt, dreg, tnew;
  } instr_t;

  typedef struct {
    instr_t     i;
    logic       st;
    logic [1:0] fdrs, fdrt, fers, fert, fmrt;
  } vec_t;

  // In-flight instruction: tnew is its D-stage value.
  typedef struct {
    logic [4:0] rs, rt, dst;
    int         tnew;
  } slot_t;

  slot_t sl [1:3];
  instr_t cur;
  logic       m_st;
  logic [1:0] m_fdrs, m_fdrt, m_fers, m_fert, m_fmrt;

  function automatic instr_t mk(
    int rs, int rt, int rd, int krt,
    int turs, int turt, int dreg, int tnew);
    instr_t x;
    x.rs = rs[4:0]; x.rt = rt[4:0]; x.rd = rd[4:0];
    x.krt = krt[0];
    x.turs = turs[1:0]; x.turt = turt[1:0];
    x.dreg = dreg[1:0]; x.tnew = tnew[1:0];
    return x;
  endfunction

  function automatic vec_t v(
    instr_t i, int st, int fdrs, int fdrt,
    int fers, int fert, int fmrt);
    vec_t x;
    x.i = i; x.st = st[0];
    x.fdrs = fdrs[1:0]; x.fdrt = fdrt[1:0];
    x.fers = fers[1:0]; x.fert = fert[1:0];
    x.fmrt = fmrt[1:0];
    return x;
  endfunction

  task automatic drive(instr_t i);
    d_rs = i.rs; d_rt = i.rt; d_rd = i.rd;
    d_krt = i.krt; d_tuse_rs = i.turs;
    d_tuse_rt = i.turt; d_dreg = i.dreg;
    d_tnew = i.tnew;
  endtask

  task automatic chk(string nm, logic [1:0] act,
                     logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, logic st,
    logic [1:0] a, logic [1:0] b, logic [1:0] c,
    logic [1:0] d, logic [1:0] e);
    chk({tag, ".stall"}, {1'b0, stall}, {1'b0, st});
    chk({tag, ".fwd_d_rs"}, fwd_d_rs, a);
    chk({tag, ".fwd_d_rt"}, fwd_d_rt, b);
    chk({tag, ".fwd_e_rs"}, fwd_e_rs, c);
    chk({tag, ".fwd_e_rt"}, fwd_e_rt, d);
    chk({tag, ".fwd_m_rt"}, fwd_m_rt, e);
  endtask

  // ---------------- reference model ----------------
  function automatic int tn(int k);
    return (sl[k].tnew > k) ? sl[k].tnew - k : 0;
  endfunction

  function automatic bit hz(logic [4:0] a, int tuse);
    for (int k = 1; k <= 2; k++)
      if (a != 0 && sl[k].dst == a && tuse < tn(k))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] fd(logic [4:0] a);
    for (int k = 1; k <= 2; k++)
      if (a != 0 && sl[k].dst == a && tn(k) == 0)
        return 2'(k);
    return 2'd0;
  endfunction

  function automatic logic [1:0] fe(logic [4:0] a);
    if (a != 0 && sl[2].dst == a && tn(2) == 0)
      return 2'd2;
    if (a != 0 && sl[3].dst == a)
      return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [4:0] dst_of(instr_t i);
    case (i.dreg)
      2'd0:    return i.rt;
      2'd1:    return i.rd;
      2'd2:    return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  task automatic model_eval();
    m_st = (cur.turs != 3 && hz(cur.rs, int'(cur.turs)))
        || (cur.krt && hz(cur.rt, int'(cur.turt)));
    m_fdrs = fd(cur.rs);
    m_fdrt = fd(cur.rt);
    m_fers = fe(sl[1].rs);
    m_fert = fe(sl[1].rt);
    m_fmrt = (sl[2].rt != 0 && sl[2].rt == sl[3].dst)
             ? 2'd3 : 2'd0;
  endtask

  task automatic model_clear();
    for (int k = 1; k <= 3; k++)
      sl[k] = '{5'd0, 5'd0, 5'd0, 0};
  endtask

  task automatic model_clock(bit st);
    sl[3] = sl[2];
    sl[2] = sl[1];
    if (st)
      sl[1] = '{5'd0, 5'd0, 5'd0, 0};
    else begin
      sl[1].rs   = (cur.turs != 3) ? cur.rs : 5'd0;
      sl[1].rt   = cur.krt ? cur.rt : 5'd0;
      sl[1].dst  = dst_of(cur);
      sl[1].tnew = int'(cur.tnew);
    end
  endtask

  // One cycle: inputs applied at negedge, outputs sampled 1ns later.
  task automatic step_model(string tag, bit do_chk);
    drive(cur);
    #1;
    model_eval();
    if (do_chk)
      chk_all(tag, m_st, m_fdrs, m_fdrt,
              m_fers, m_fert, m_fmrt);
    @(posedge clk);
    model_clock(m_st);
    @(negedge clk);
  endtask

  function automatic logic [4:0] rreg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  instr_t NOP, LW8, ADDU989, ADDU312, BEQ, JAL, JR;
  instr_t LW5, SW, ORI, ADDU400;
  vec_t tab [26];
  bit   held;

  initial begin
    NOP     = mk(0, 0, 0, 0, 3, 0, 3, 0);
    LW8     = mk(1, 8, 0, 0, 1, 0, 0, 3);
    ADDU989 = mk(8, 8, 9, 1, 1, 1, 1, 2);
    ADDU312 = mk(1, 2, 3, 1, 1, 1, 1, 2);
    BEQ     = mk(3, 0, 0, 1, 0, 0, 3, 0);
    JAL     = mk(0, 0, 0, 0, 3, 0, 2, 1);
    JR      = mk(31, 0, 0, 0, 0, 0, 3, 0);
    LW5     = mk(1, 5, 0, 0, 1, 0, 0, 3);
    SW      = mk(6, 5, 0, 1, 1, 2, 3, 0);
    ORI     = mk(0, 0, 0, 0, 1, 0, 0, 2);
    ADDU400 = mk(0, 0, 4, 1, 1, 1, 1, 2);

    tab[0]  = v(LW8,     0, 0, 0, 0, 0, 0);
    tab[1]  = v(ADDU989, 1, 0, 0, 0, 0, 0);
    tab[2]  = v(ADDU989, 0, 0, 0, 0, 0, 0);
    tab[3]  = v(NOP,     0, 0, 0, 3, 3, 0);
    tab[4]  = v(NOP,     0, 0, 0, 0, 0, 0);
    tab[5]  = v(NOP,     0, 0, 0, 0, 0, 0);
    tab[6]  = v(ADDU312, 0, 0, 0, 0, 0, 0);
    tab[7]  = v(BEQ,     1, 0, 0, 0, 0, 0);
    tab[8]  = v(BEQ,     0, 2, 0, 0, 0, 0);
    tab[9]  = v(NOP,     0, 0, 0, 3, 0, 0);
    tab[10] = v(NOP,     0, 0, 0, 0, 0, 0);
    tab[11] = v(JAL,     0, 0, 0, 0, 0, 0);
    tab[12] = v(JR,      0, 1, 0, 0, 0, 0);
    tab[13] = v(NOP,     0, 0, 0, 2, 0, 0);
    tab[14] = v(NOP,     0, 0, 0, 0, 0, 0);
    tab[15] = v(NOP,     0, 0, 0, 0, 0, 0);
    tab[16] = v(LW5,     0, 0, 0, 0, 0, 0);
    tab[17] = v(SW,      0, 0, 0, 0, 0, 0);
    tab[18] = v(NOP,     0, 0, 0, 0, 0, 0);
    tab[19] = v(NOP,     0, 0, 0, 0, 0, 3);
    tab[20] = v(NOP,     0, 0, 0, 0, 0, 0);
    tab[21] = v(ORI,     0, 0, 0, 0, 0, 0);
    tab[22] = v(ADDU400, 0, 0, 0, 0, 0, 0);
    tab[23] = v(NOP,     0, 0, 0, 0, 0, 0);
    tab[24] = v(NOP,     0, 0, 0, 0, 0, 0);
    tab[25] = v(NOP,     0, 0, 0, 0, 0, 0);

    // Reset state, with a would-be hazard on the inputs.
    reset_n = 1'b0;
    cur = ADDU989;
    drive(cur);
    model_clear();
    @(negedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed cycle table.
    for (int n = 0; n < 26; n++) begin
      cur = tab[n].i;
      drive(cur);
      #1;
      model_eval();
      chk_all($sformatf("tab%0d", n), tab[n].st,
              tab[n].fdrs, tab[n].fdrt, tab[n].fers,
              tab[n].fert, tab[n].fmrt);
      @(posedge clk);
      model_clock(m_st);
      @(negedge clk);
    end

    // Reset between edges with lw in E and a consumer in D.
    cur = LW8;
    step_model("rst_lw", 1'b1);
    cur = ADDU989;
    drive(cur);
    #1;
    chk("rst_pre.stall", {1'b0, stall}, 2'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk_all("rst_mid", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_all("rst_hold", 0, 0, 0, 0, 0, 0);
    model_clear();
    reset_n = 1'b1;
    cur = NOP;
    for (int n = 0; n < 3; n++) begin
      drive(cur);
      #1;
      chk_all($sformatf("rst_post%0d", n),
              0, 0, 0, 0, 0, 0);
      @(posedge clk);
      model_clock(1'b0);
      @(negedge clk);
    end

    // Random traffic; a stalled instruction stays in D.
    held = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!held) begin
        cur.rs   = rreg();
        cur.rt   = rreg();
        cur.rd   = rreg();
        cur.krt  = 1'($urandom_range(0, 1));
        cur.turs = 2'($urandom_range(0, 3));
        cur.turt = 2'($urandom_range(0, 2));
        cur.dreg = 2'($urandom_range(0, 3));
        cur.tnew = 2'($urandom_range(0, 3));
      end
      drive(cur);
      #1;
      model_eval();
      chk_all($sformatf("rnd%0d", n), m_st, m_fdrs,
              m_fdrt, m_fers, m_fert, m_fmrt);
      held = m_st;
      @(posedge clk);
      model_clock(m_st);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
